// File: rtl/vcxo_pkg.sv
// Shared definitions for the VCXO discipline loop and its lock monitor.
package vcxo_pkg;

  // Width of frequency-error and PWM words throughout the VCXO path.
  localparam int ERR_W = 24;

  // Full-scale PWM word; equals the TCXO gate length in kHz.
  localparam int PWM_MAX = 49152;

  // Lock-state encoding as seen by the MCU on lock_state.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SLIP   = 2'd2,
    ST_FAULT  = 2'd3
  } lock_state_t;

endpackage

// File: rtl/vcxo_abs_sat.sv
// Signed-to-unsigned magnitude with saturation. The single value with no
// positive counterpart (most negative) maps to the largest positive value,
// so the result always fits in ERR_W-1 magnitude bits.
module vcxo_abs_sat
  import vcxo_pkg::*;
(
  input  logic signed [ERR_W-1:0] value,
  output logic        [ERR_W-1:0] magnitude
);

  localparam logic [ERR_W-1:0] MOST_NEG = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] MOST_POS = {1'b0, {(ERR_W-1){1'b1}}};

  // Magnitude, clamping the most negative input.
  always_comb begin
    magnitude = $unsigned(value);
    if ($unsigned(value) == MOST_NEG) begin
      magnitude = MOST_POS;
    end else if (value[ERR_W-1]) begin
      magnitude = $unsigned(-value);
    end
  end

endmodule

// File: rtl/vcxo_lock_monitor.sv
// Lock-quality monitor for the VCXO discipline loop.
// Qualifies lock with hysteresis, detects a tuning rail stuck at either end,
// and keeps MCU-readable statistics (lock-loss count, peak error).
//
// Interface: meas_valid is a one-cycle strobe with no back-pressure; every
// cycle with meas_valid=1 is one measurement (freq_error and pwm sampled in
// that cycle), back-to-back strobes included. All outputs are registered and
// reflect a measurement on the cycle after its strobe. clear_stats is an
// independent one-cycle pulse acting on the statistics only.
module vcxo_lock_monitor
  import vcxo_pkg::*;
#(
  parameter int LOCK_WINDOW   = 2,
  parameter int LOCK_COUNT    = 8,
  parameter int UNLOCK_WINDOW = 8,
  parameter int UNLOCK_COUNT  = 3,
  parameter int RAIL_MARGIN   = 256,
  parameter int FAULT_MEAS    = 64
) (
  input  logic                    tcxo_clk_in,
  input  logic                    rst_n_in,
  input  logic                    meas_valid,
  input  logic signed [ERR_W-1:0] freq_error,
  input  logic signed [ERR_W-1:0] pwm,
  input  logic                    clear_stats,
  output logic                    locked,
  output logic [1:0]              lock_state,
  output logic                    rail_fault,
  output logic [15:0]             lock_lost_count,
  output logic [ERR_W-1:0]        err_peak
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
  localparam int MEAS_W = $clog2(FAULT_MEAS + 1);

  localparam logic [ERR_W-1:0]        LOCK_WIN_U   = ERR_W'(LOCK_WINDOW);
  localparam logic [ERR_W-1:0]        UNLOCK_WIN_U = ERR_W'(UNLOCK_WINDOW);
  localparam logic signed [ERR_W-1:0] RAIL_LO      = ERR_W'(RAIL_MARGIN);
  localparam logic signed [ERR_W-1:0] RAIL_HI      = ERR_W'(PWM_MAX - RAIL_MARGIN);
  localparam logic [GOOD_W-1:0]       GOOD_TARGET  = GOOD_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0]        BAD_TARGET   = BAD_W'(UNLOCK_COUNT);
  localparam logic [MEAS_W-1:0]       MEAS_TARGET  = MEAS_W'(FAULT_MEAS);

  lock_state_t        state_q;
  logic               locked_q;
  logic               fault_q;
  logic [GOOD_W-1:0]  good_cnt_q;
  logic [BAD_W-1:0]   bad_cnt_q;
  logic [MEAS_W-1:0]  meas_cnt_q;
  logic [15:0]        lost_cnt_q;
  logic [ERR_W-1:0]   peak_q;

  logic [ERR_W-1:0]   abs_err;
  logic               is_good;
  logic               is_bad;
  logic               at_rail;
  logic [GOOD_W-1:0]  good_inc;
  logic [BAD_W-1:0]   bad_inc;
  logic [MEAS_W-1:0]  meas_inc;
  logic               lose_lock;

  vcxo_abs_sat u_abs (
    .value     (freq_error),
    .magnitude (abs_err)
  );

  // Per-measurement classification and candidate counter values.
  always_comb begin
    is_good   = (abs_err <= LOCK_WIN_U);
    is_bad    = (abs_err > UNLOCK_WIN_U);
    at_rail   = (pwm <= RAIL_LO) || (pwm >= RAIL_HI);
    good_inc  = is_good ? (good_cnt_q + 1'b1) : '0;
    meas_inc  = at_rail ? (meas_cnt_q + 1'b1) : '0;
    bad_inc   = bad_cnt_q + 1'b1;
    lose_lock = meas_valid && (state_q == ST_SLIP) && is_bad &&
                (bad_inc == BAD_TARGET);
  end

  // Lock FSM: acquisition, slip tolerance and rail-fault handling.
  always_ff @(posedge tcxo_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_SEARCH;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      meas_cnt_q <= '0;
    end else if (meas_valid) begin
      case (state_q)
        ST_SEARCH: begin
          good_cnt_q <= good_inc;
          meas_cnt_q <= meas_inc;
          // Qualifying lock wins over a simultaneous rail timeout.
          if (good_inc == GOOD_TARGET) begin
            state_q    <= ST_LOCKED;
            locked_q   <= 1'b1;
            good_cnt_q <= '0;
            meas_cnt_q <= '0;
          end else if (meas_inc == MEAS_TARGET) begin
            state_q    <= ST_FAULT;
            fault_q    <= 1'b1;
            good_cnt_q <= '0;
            meas_cnt_q <= '0;
          end
        end
        ST_LOCKED: begin
          if (is_bad) begin
            state_q   <= ST_SLIP;
            bad_cnt_q <= BAD_W'(1);
          end
        end
        ST_SLIP: begin
          if (is_bad) begin
            if (bad_inc == BAD_TARGET) begin
              state_q    <= ST_SEARCH;
              locked_q   <= 1'b0;
              bad_cnt_q  <= '0;
              good_cnt_q <= '0;
              meas_cnt_q <= '0;
            end else begin
              bad_cnt_q <= bad_inc;
            end
          end else begin
            state_q   <= ST_LOCKED;
            bad_cnt_q <= '0;
          end
        end
        ST_FAULT: begin
          if (!at_rail) begin
            state_q    <= ST_SEARCH;
            fault_q    <= 1'b0;
            locked_q   <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            meas_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= ST_SEARCH;
          locked_q   <= 1'b0;
          fault_q    <= 1'b0;
          good_cnt_q <= '0;
          bad_cnt_q  <= '0;
          meas_cnt_q <= '0;
        end
      endcase
    end
  end

  // Statistics: clear_stats discards any same-cycle increment or peak update.
  always_ff @(posedge tcxo_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lost_cnt_q <= '0;
      peak_q     <= '0;
    end else if (clear_stats) begin
      lost_cnt_q <= '0;
      peak_q     <= '0;
    end else begin
      if (lose_lock && (lost_cnt_q != 16'hFFFF)) begin
        lost_cnt_q <= lost_cnt_q + 16'd1;
      end
      if (meas_valid && (abs_err > peak_q)) begin
        peak_q <= abs_err;
      end
    end
  end

  assign locked          = locked_q;
  assign lock_state      = state_q;
  assign rail_fault      = fault_q;
  assign lock_lost_count = lost_cnt_q;
  assign err_peak        = peak_q;

endmodule

// File: tb/tb_vcxo_lock_monitor.sv
// Self-checking bench for vcxo_lock_monitor: directed scenarios followed by
// randomized measurements, compared against a behavioural model.
module tb_vcxo_lock_monitor;
  import vcxo_pkg::*;

  localparam int LOCK_WIN   = 2;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_WIN = 8;
  localparam int UNLOCK_CNT = 3;
  localparam int RAIL_M     = 256;
  localparam int FAULT_N    = 64;
  localparam int EXP_W      = 44;

  logic                    tcxo_clk_in;
  logic                    rst_n_in;
  logic                    meas_valid;
  logic signed [ERR_W-1:0] freq_error;
  logic signed [ERR_W-1:0] pwm;
  logic                    clear_stats;
  logic                    locked;
  logic [1:0]              lock_state;
  logic                    rail_fault;
  logic [15:0]             lock_lost_count;
  logic [ERR_W-1:0]        err_peak;

  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Behavioural model state (S/L/P/F = search/locked/slip/fault)
  int m_state, m_good, m_bad, m_meas, m_lost, m_peak;
  bit m_locked, m_fault;

  vcxo_lock_monitor dut (
    .tcxo_clk_in     (tcxo_clk_in),
    .rst_n_in        (rst_n_in),
    .meas_valid      (meas_valid),
    .freq_error      (freq_error),
    .pwm             (pwm),
    .clear_stats     (clear_stats),
    .locked          (locked),
    .lock_state      (lock_state),
    .rail_fault      (rail_fault),
    .lock_lost_count (lock_lost_count),
    .err_peak        (err_peak)
  );

  // Clock and reset defaults
  initial begin
    tcxo_clk_in = 1'b0;
    forever #5 tcxo_clk_in = ~tcxo_clk_in;
  end

  task automatic chk(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_meas = 0;
    m_lost = 0; m_peak = 0; m_locked = 0; m_fault = 0;
  endfunction

  function automatic void model_step(bit v, int e, int p, bit clr);
    int  a;
    bit  rail;
    bit  drop;
    drop = 0;
    a = (e < 0) ? -e : e;
    if (a > 8388607) a = 8388607;
    rail = (p <= RAIL_M) || (p >= PWM_MAX - RAIL_M);
    if (v) begin
      if (m_state == 0) begin
        m_good = (a <= LOCK_WIN) ? m_good + 1 : 0;
        m_meas = rail ? m_meas + 1 : 0;
        if (m_good == LOCK_CNT) begin
          m_state = 1; m_locked = 1; m_good = 0; m_meas = 0;
        end else if (m_meas == FAULT_N) begin
          m_state = 3; m_fault = 1; m_good = 0; m_meas = 0;
        end
      end else if (m_state == 1) begin
        if (a > UNLOCK_WIN) begin m_state = 2; m_bad = 1; end
      end else if (m_state == 2) begin
        if (a > UNLOCK_WIN) begin
          m_bad = m_bad + 1;
          if (m_bad == UNLOCK_CNT) begin
            m_state = 0; m_locked = 0; m_bad = 0; m_good = 0; m_meas = 0;
            drop = 1;
          end
        end else begin
          m_state = 1; m_bad = 0;
        end
      end else begin
        if (!rail) begin
          m_state = 0; m_fault = 0; m_locked = 0;
          m_good = 0; m_bad = 0; m_meas = 0;
        end
      end
    end
    if (clr) begin
      m_lost = 0; m_peak = 0;
    end else begin
      if (drop && m_lost < 65535) m_lost = m_lost + 1;
      if (v && a > m_peak) m_peak = a;
    end
  endfunction

  // Scoreboard: queue the model's expectation, then pop and compare.
  task automatic score(input string tag);
    logic [EXP_W-1:0] e;
    exp_q.push_back({m_locked, 2'(m_state), m_fault, 16'(m_lost), 24'(m_peak)});
    e = exp_q.pop_front();
    chk({tag, ".locked"}, locked,          e[43]);
    chk({tag, ".state"},  lock_state,      e[42:41]);
    chk({tag, ".fault"},  rail_fault,      e[40]);
    chk({tag, ".lost"},   lock_lost_count, e[39:24]);
    chk({tag, ".peak"},   err_peak,        e[23:0]);
  endtask

  // Driver: one cycle of inputs, then model update and compare.
  task automatic drive(input bit v, input int e, input int p, input bit clr,
                       input string tag);
    logic signed [ERR_W-1:0] ev;
    logic signed [ERR_W-1:0] pv;
    ev = ERR_W'(e);
    pv = ERR_W'(p);
    @(negedge tcxo_clk_in);
    meas_valid  = v;
    freq_error  = ev;
    pwm         = pv;
    clear_stats = clr;
    @(posedge tcxo_clk_in);
    #1;
    meas_valid  = 1'b0;
    clear_stats = 1'b0;
    model_step(v, int'(ev), int'(pv), clr);
    score(tag);
  endtask

  task automatic meas(input int e, input int p, input string tag);
    drive(1'b1, e, p, 1'b0, tag);
  endtask

  task automatic lock_up(input string tag);
    for (int i = 0; i < LOCK_CNT; i++) meas(1, 30000, tag);
  endtask

  task automatic drop_lock(input string tag);
    for (int i = 0; i < UNLOCK_CNT; i++) meas(12, 30000, tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge tcxo_clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    score(tag);
    @(negedge tcxo_clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    int mode;
    int e;
    int p;
    int r;
    bit v;
    bit c;

    rst_n_in    = 1'b0;
    meas_valid  = 1'b0;
    freq_error  = '0;
    pwm         = '0;
    clear_stats = 1'b0;
    model_reset();
    #12;
    score("reset");
    chk("reset.state_const", lock_state, 0);
    @(negedge tcxo_clk_in);
    rst_n_in = 1'b1;

    // Acquisition: locked rises after the 8th good strobe
    for (int i = 0; i < LOCK_CNT - 1; i++) meas(1, 30000, "acq");
    chk("acq.not_yet", locked, 0);
    meas(1, 30000, "acq8");
    chk("acq8.locked_const", locked, 1);
    chk("acq8.state_const", lock_state, 1);
    chk("acq8.peak_const", err_peak, 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 500, 100, 1'b0, "idle");

    // Slip then loss of lock
    meas(12, 30000, "slip1");
    chk("slip1.state_const", lock_state, 2);
    chk("slip1.locked_const", locked, 1);
    meas(12, 30000, "slip2");
    meas(12, 30000, "slip3");
    chk("slip3.state_const", lock_state, 0);
    chk("slip3.lost_const", lock_lost_count, 1);

    // Slip recovery and hysteresis band while locked
    lock_up("relock");
    meas(12, 30000, "rec_slip");
    meas(3, 30000, "rec_back");
    chk("rec_back.state_const", lock_state, 1);
    for (int i = 0; i < 20; i++) meas(5, 30000, "hyst_locked");
    chk("hyst_locked.state_const", lock_state, 1);
    drop_lock("drop2");
    for (int i = 0; i < 20; i++) meas(-5, 30000, "hyst_search");
    chk("hyst_search.locked_const", locked, 0);

    // Rail fault and recovery
    for (int i = 0; i < FAULT_N - 1; i++) meas(-500, 100, "rail");
    chk("rail63.state_const", lock_state, 0);
    meas(-500, 100, "rail64");
    chk("rail64.state_const", lock_state, 3);
    chk("rail64.fault_const", rail_fault, 1);
    meas(-500, 100, "fault_hold");
    meas(0, 20000, "fault_exit");
    chk("fault_exit.fault_const", rail_fault, 0);

    // Peak saturation and clear priority
    meas(-8388608, 20000, "sat");
    chk("sat.peak_const", err_peak, 8388607);
    drive(1'b1, 40, 20000, 1'b1, "clr_same");
    chk("clr_same.peak_const", err_peak, 0);
    meas(40, 20000, "after_clr");
    chk("after_clr.peak_const", err_peak, 40);

    // Async reset in the middle of SLIP
    async_reset("pre_slip_rst");
    lock_up("slip_rst_lock");
    meas(12, 30000, "slip_rst_enter");
    async_reset("mid_slip_rst");
    chk("mid_slip_rst.locked_const", locked, 0);

    // Lock-loss count saturation
    lock_up("sat_lock");
    @(negedge tcxo_clk_in);
    force dut.lost_cnt_q = 16'd65534;
    @(negedge tcxo_clk_in);
    release dut.lost_cnt_q;
    m_lost = 65534;
    drop_lock("sat_drop1");
    chk("sat_drop1.lost_const", lock_lost_count, 65535);
    lock_up("sat_relock");
    drop_lock("sat_drop2");
    chk("sat_drop2.lost_const", lock_lost_count, 65535);

    // Randomized measurements in blocks of normal or rail-heavy traffic
    for (int blk = 0; blk < 16; blk++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 120; i++) begin
        r = $urandom_range(0, 9);
        if (r <= 5)      e = $urandom_range(0, 2);
        else if (r <= 7) e = $urandom_range(3, 8);
        else if (r == 8) e = $urandom_range(9, 20);
        else             e = $urandom_range(0, 8388607);
        if ($urandom_range(0, 1) == 1) e = -e;
        if (mode == 0 || $urandom_range(0, 7) == 0) begin
          p = ($urandom_range(0, 1) == 1) ? $urandom_range(48896, 60000)
                                          : -$urandom_range(0, 5000) + 256;
        end else begin
          p = $urandom_range(257, 48895);
        end
        v = ($urandom_range(0, 9) < 8);
        c = ($urandom_range(0, 49) == 0);
        drive(v, e, p, c, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
